sm_window_sched: RTL and testbench

//  Sequences the BRAM read port and 3-bit rotate select of the 8-byte pixel window datapath.

---
 rtl/sm_window_sched_pkg.sv | 22 ++
 rtl/sm_window_sched_if.sv | 32 +++
 rtl/sm_window_sched_tag_pipe.sv | 49 ++++
 rtl/sm_window_sched.sv | 121 ++++++++++++
 tb/tb_sm_window_sched.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_window_sched_pkg.sv
// Shared types and constants for the pixel-window read scheduler.
package sm_window_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_ISSUE1 = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int SEL_W       = 3;
    localparam int SWEEP_LEN   = 8;
    localparam int BRAM_RD_LAT = 1;
    // BRAM read latency plus the previous-word capture register
    localparam int TAG_DEPTH   = BRAM_RD_LAT + 1;

    function automatic logic [1:0] eff_stride(input logic [1:0] stride);
        return (stride == 2'd0) ? 2'd1 : stride;
    endfunction

endpackage

// File: rtl/sm_window_sched_if.sv
// Control, configuration and BRAM/datapath sequencing signals of the window scheduler.
interface sm_window_sched_if
    import sm_window_sched_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_windows;
    logic [1:0]        stride;
    logic              sweep_all;
    logic [SEL_W-1:0]  rot_cfg;
    logic              out_ready;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [SEL_W-1:0]  sel_mux;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, num_windows, stride, sweep_all, rot_cfg, out_ready,
        input  bram_en, bram_addr, sel_mux, out_valid, out_last, busy, done
    );

    modport slave (
        input  start, base_addr, num_windows, stride, sweep_all, rot_cfg, out_ready,
        output bram_en, bram_addr, sel_mux, out_valid, out_last, busy, done
    );
endinterface

// File: rtl/sm_window_sched_tag_pipe.sv
// Two-stage tag delay line: carries {valid, sel, last} from pair issue to window-valid cycle.
module sm_tag_pipe
    import sm_window_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [SEL_W-1:0] push_sel,
    input  logic             push_last,
    output logic             out_vld,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_last,
    output logic             pending
);
    logic             vld_p0, vld_p1;
    logic [SEL_W-1:0] sel_p0, sel_p1;
    logic             last_p0, last_p1;

    // sel/last only move with a valid tag, so sel_mux holds its value through bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            sel_p0  <= '0;
            sel_p1  <= '0;
            last_p0 <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            // p0: BRAM returns word A
            vld_p0 <= push;
            if (push) begin
                sel_p0  <= push_sel;
                last_p0 <= push_last;
            end
            // p1: word A captured, word A+1 live on doutb
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                sel_p1  <= sel_p0;
                last_p1 <= last_p0;
            end
        end
    end

    assign out_vld  = vld_p1;
    assign out_sel  = sel_p1;
    assign out_last = vld_p1 & last_p1;
    assign pending  = vld_p0;

endmodule

// File: rtl/sm_window_sched.sv
// Schedules (A, A+1) BRAM read pairs and rotate selects for the 8-byte pixel window datapath.
module sm_window_sched
    import sm_window_sched_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
)(
    input  logic clk,
    input  logic rst_n,
    sm_window_sched_if.slave bus
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_a;
    logic [CNT_W-1:0]  num_lat, win_cnt;
    logic [1:0]        stride_lat;
    logic              sweep_lat;
    logic [SEL_W-1:0]  rot_lat, sel_cnt;

    logic              last_sel, last_win;
    logic              push, pending;
    logic [SEL_W-1:0]  push_sel;
    logic              push_last;
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;

    assign last_sel  = !sweep_lat || (sel_cnt == SEL_W'(SWEEP_LEN - 1));
    assign last_win  = (win_cnt == num_lat - CNT_W'(1));
    assign push_sel  = sweep_lat ? sel_cnt : rot_lat;
    assign push_last = last_sel && last_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bram_en   = 1'b0;
        bram_addr = '0;
        push      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_nxt = (bus.num_windows == '0) ? ST_DONE : ST_ISSUE0;
            end
            ST_ISSUE0: begin
                // a pair is only started when the consumer has credit for its output
                bram_addr = addr_a;
                if (bus.out_ready) begin
                    bram_en   = 1'b1;
                    push      = 1'b1;
                    state_nxt = ST_ISSUE1;
                end
            end
            ST_ISSUE1: begin
                bram_en   = 1'b1;
                bram_addr = addr_a + ADDR_W'(1);
                state_nxt = (last_sel && last_win) ? ST_DRAIN : ST_ISSUE0;
            end
            ST_DRAIN: begin
                if (!pending) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a     <= '0;
            num_lat    <= '0;
            win_cnt    <= '0;
            stride_lat <= '0;
            sweep_lat  <= 1'b0;
            rot_lat    <= '0;
            sel_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        addr_a     <= bus.base_addr;
                        num_lat    <= bus.num_windows;
                        stride_lat <= bus.stride;
                        sweep_lat  <= bus.sweep_all;
                        rot_lat    <= bus.rot_cfg;
                        win_cnt    <= '0;
                        sel_cnt    <= '0;
                    end
                end
                ST_ISSUE1: begin
                    if (last_sel) begin
                        sel_cnt <= '0;
                        addr_a  <= addr_a + ADDR_W'(eff_stride(stride_lat));
                        win_cnt <= win_cnt + CNT_W'(1);
                    end else begin
                        sel_cnt <= sel_cnt + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    sm_tag_pipe u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_sel  (push_sel),
        .push_last (push_last),
        .out_vld   (bus.out_valid),
        .out_sel   (bus.sel_mux),
        .out_last  (bus.out_last),
        .pending   (pending)
    );

    assign bus.bram_en   = bram_en;
    assign bus.bram_addr = bram_addr;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);

endmodule

// File: tb/tb_sm_window_sched.sv
// Randomised bench: scheduler + behavioural BRAM and window datapath, checked against a window-list model.
module tb_sm_window_sched;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [2:0]  sel;
        logic        last;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sm_window_sched_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    sm_window_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [DEPTH];
    logic [31:0] doutb = '0;
    logic [31:0] prev  = '0;

    always @(posedge clk) begin
        if (bus.bram_en) doutb <= mem[bus.bram_addr];
        prev <= doutb;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [ADDR_W-1:0] exp_rd_q[$];
    exp_t              exp_out_q[$];
    int                issue_q[$];
    int  cyc = 0;
    int  rd_idx = 0, rd_total = 0, done_cnt = 0, done_cyc = 0, last_out_cyc = 0, start_cyc = 0;
    bit  run_active = 0;
    bit  prev_vld = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard on the falling edge
    always @(negedge clk) begin
        logic [ADDR_W-1:0] a;
        exp_t              e;
        logic [63:0]       win, rot;
        int                sh, t0;
        if (rst_n) begin
            if (bus.bram_en) begin
                rd_total++;
                if (exp_rd_q.size() == 0) chk("rd_unexp", bus.bram_en, 0);
                else begin
                    a = exp_rd_q.pop_front();
                    chk("rd_addr", bus.bram_addr, a);
                end
                if (rd_idx % 2 == 0) begin
                    chk("rd_credit", bus.out_ready, 1);
                    issue_q.push_back(cyc);
                end
                rd_idx++;
            end
            if (bus.out_valid) begin
                chk("valid_gap", prev_vld, 0);
                if (exp_out_q.size() == 0) chk("out_unexp", bus.out_valid, 0);
                else begin
                    e   = exp_out_q.pop_front();
                    win = {doutb, prev};
                    sh  = 8 * int'(bus.sel_mux);
                    rot = (win >> sh) | (win << (64 - sh));
                    chk("out_sel", bus.sel_mux, e.sel);
                    chk("out_last", bus.out_last, e.last);
                    chk("out_data", rot, e.data);
                end
                if (issue_q.size() != 0) begin
                    t0 = issue_q.pop_front();
                    chk("out_latency", cyc - t0, 2);
                end
                if (bus.out_last) last_out_cyc = cyc;
            end
            prev_vld = bus.out_valid;
            if (bus.done) begin
                chk("done_expected", bus.done, run_active);
                run_active = 0;
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic build_exp(input int base, input int num, input int strd, input bit sweep, input int rot);
        int se, ns, a, a1;
        exp_t e;
        logic [7:0]  b [8];
        logic [31:0] lo, hi;
        se = (strd == 0) ? 1 : strd;
        ns = sweep ? 8 : 1;
        for (int w = 0; w < num; w++) begin
            a  = (base + w * se) % DEPTH;
            a1 = (a + 1) % DEPTH;
            lo = mem[a];
            hi = mem[a1];
            for (int k = 0; k < 4; k++) begin
                b[k]     = lo[8*k +: 8];
                b[k + 4] = hi[8*k +: 8];
            end
            for (int s = 0; s < ns; s++) begin
                e.sel  = sweep ? 3'(s) : 3'(rot);
                e.last = (w == num - 1) && (s == ns - 1);
                for (int k = 0; k < 8; k++) e.data[8*k +: 8] = b[(k + int'(e.sel)) % 8];
                exp_rd_q.push_back(ADDR_W'(a));
                exp_rd_q.push_back(ADDR_W'(a1));
                exp_out_q.push_back(e);
            end
        end
    endtask

    task automatic flush();
        exp_rd_q.delete();
        exp_out_q.delete();
        issue_q.delete();
        rd_idx = 0;
        prev_vld = 0;
        run_active = 0;
    endtask

    task automatic randomize_cfg();
        bus.base_addr   = ADDR_W'($urandom);
        bus.num_windows = CNT_W'($urandom);
        bus.stride      = 2'($urandom);
        bus.sweep_all   = 1'($urandom);
        bus.rot_cfg     = 3'($urandom);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for 5 cycles then random
    task automatic run(input int base, input int num, input int strd, input bit sweep, input int rot, input int mode);
        int d0, rd0, budget;
        bit done_ok;
        build_exp(base, num, strd, sweep, rot);
        d0 = done_cnt;
        rd0 = rd_total;
        run_active = 1;
        @(posedge clk); #1;
        bus.base_addr   = ADDR_W'(base);
        bus.num_windows = CNT_W'(num);
        bus.stride      = 2'(strd);
        bus.sweep_all   = sweep;
        bus.rot_cfg     = 3'(rot);
        bus.out_ready   = (mode != 2);
        bus.start       = 1'b1;
        start_cyc       = cyc;
        budget  = 30 + num * (sweep ? 8 : 1) * 10;
        done_ok = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (!run_active) begin
                done_ok = 1;
                break;
            end
            if (i == 1) chk("busy_run", bus.busy, 1);
            if (mode == 2 && i == 6) chk("stall_no_read", rd_total - rd0, 0);
            bus.start = ($urandom_range(0, 3) == 0);
            randomize_cfg();
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 2) != 0);
                default: bus.out_ready = (i >= 6) ? ($urandom_range(0, 2) != 0) : 1'b0;
            endcase
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        chk("run_done", done_ok, 1);
        chk("rd_left", exp_rd_q.size(), 0);
        chk("out_left", exp_out_q.size(), 0);
        chk("busy_idle", bus.busy, 0);
        chk("done_once", done_cnt - d0, 1);
        if (num > 0) chk("done_after_last", done_cyc - last_out_cyc, 1);
        else         chk("done_lat_zero", (done_cyc - start_cyc) <= 2, 1);
        if (!done_ok) begin
            rst_n = 1'b0;
            flush();
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    task automatic reset_mid_issue1();
        int  d0;
        bit  found;
        build_exp(300, 4, 1, 1'b1, 0);
        run_active = 1;
        @(posedge clk); #1;
        bus.base_addr   = ADDR_W'(300);
        bus.num_windows = CNT_W'(4);
        bus.stride      = 2'd1;
        bus.sweep_all   = 1'b1;
        bus.out_ready   = 1'b1;
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.bram_en && bus.bram_addr == ADDR_W'(301)) begin
                found = 1;
                break;
            end
        end
        chk("rst_reach_issue1", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {bus.bram_en, bus.bram_addr, bus.sel_mux, bus.out_valid,
                               bus.out_last, bus.busy, bus.done}, 0);
        flush();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_idle", bus.busy, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        bus.base_addr = '0;
        bus.num_windows = '0;
        bus.stride = '0;
        bus.sweep_all = 1'b0;
        bus.rot_cfg = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {bus.bram_en, bus.bram_addr, bus.sel_mux, bus.out_valid,
                           bus.out_last, bus.busy, bus.done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", {bus.bram_en, bus.out_valid, bus.busy, bus.done}, 0);

        run(5, 1, 1, 1'b1, 0, 0);
        run(0, 3, 2, 1'b0, 3, 0);
        run(200, 2, 1, 1'b1, 0, 2);
        run(1023, 1, 1, 1'b0, 5, 0);
        run(1022, 2, 1, 1'b1, 0, 1);
        run(77, 0, 1, 1'b1, 0, 0);
        reset_mid_issue1();
        run(10, 2, 3, 1'b1, 0, 1);
        for (int r = 0; r < 10; r++)
            run($urandom_range(0, DEPTH - 1), $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom), $urandom_range(0, 7), $urandom_range(0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
